// File: rtl/seg_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_pkg
// Brief    : Shared constants and types for the 4-digit seven-segment scanner.
// Revision : 1.0 - initial release
// ============================================================================
package seg_display_pkg;

    typedef logic [1:0] slot_idx_t;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam logic [3:0] ANODE_PAT [0:3] = '{
        4'b1110, 4'b1101, 4'b1011, 4'b0111
    };

endpackage : seg_display_pkg
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Brief    : BCD to active-low seven-segment decoder; non-decimal codes give a dash.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_DIGIT[0];
            4'd1:    o_seg = SEG_DIGIT[1];
            4'd2:    o_seg = SEG_DIGIT[2];
            4'd3:    o_seg = SEG_DIGIT[3];
            4'd4:    o_seg = SEG_DIGIT[4];
            4'd5:    o_seg = SEG_DIGIT[5];
            4'd6:    o_seg = SEG_DIGIT[6];
            4'd7:    o_seg = SEG_DIGIT[7];
            4'd8:    o_seg = SEG_DIGIT[8];
            4'd9:    o_seg = SEG_DIGIT[9];
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/seg_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_scan
// Brief    : Time-multiplexed MM:SS display driver with frame snapshot and
//            adjust-mode blinking of the selected digit pair.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_scan
    import seg_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_ones,
    input  logic       adj_en,
    input  logic       adj_sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] c_REF_MAX = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] c_BLK_MAX = BW'(BLINK_DIV - 1);

    logic [RW-1:0] r_refresh_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic          r_adj_en_d;
    slot_idx_t     r_idx;
    logic [3:0]    r_snap_sec_tens;
    logic [3:0]    r_snap_min_ones;
    logic [3:0]    r_snap_min_tens;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_tick;
    logic          w_blink_wrap;
    logic          w_adj_rise;
    logic          w_phase_next;
    slot_idx_t     w_idx_next;
    logic [3:0]    w_digit;
    logic [6:0]    w_seg;
    logic          w_blank;

    assign w_tick       = (r_refresh_cnt == c_REF_MAX);
    assign w_blink_wrap = (r_blink_cnt == c_BLK_MAX);
    assign w_adj_rise   = adj_en & ~r_adj_en_d;
    assign w_idx_next   = r_idx + 2'd1;

    // Blanking on a tick must see the phase this same edge produces
    assign w_phase_next = w_adj_rise   ? 1'b0 :
                          w_blink_wrap ? ~r_blink_phase : r_blink_phase;

    // Digit 0 opens a frame and is shown live; the rest come from the snapshot
    // taken on that same edge, so sec_ones itself never needs a snapshot copy.
    always_comb begin
        w_digit = sec_ones;
        case (w_idx_next)
            2'd0:    w_digit = sec_ones;
            2'd1:    w_digit = r_snap_sec_tens;
            2'd2:    w_digit = r_snap_min_ones;
            default: w_digit = r_snap_min_tens;
        endcase
    end

    assign w_blank = adj_en & w_phase_next & (adj_sel ? ~w_idx_next[1] : w_idx_next[1]);

    seg7_decode u_decode (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_refresh_cnt   <= '0;
            r_blink_cnt     <= '0;
            r_blink_phase   <= 1'b0;
            r_adj_en_d      <= 1'b0;
            r_idx           <= 2'd3;
            r_snap_sec_tens <= 4'd0;
            r_snap_min_ones <= 4'd0;
            r_snap_min_tens <= 4'd0;
            r_an            <= ANODE_OFF;
            r_seg           <= SEG_BLANK;
            r_dp            <= 1'b1;
        end else begin
            r_adj_en_d    <= adj_en;
            r_blink_phase <= w_phase_next;
            r_refresh_cnt <= w_tick ? '0 : r_refresh_cnt + 1'b1;
            r_blink_cnt   <= (w_adj_rise || w_blink_wrap) ? '0 : r_blink_cnt + 1'b1;
            if (w_tick) begin
                r_idx <= w_idx_next;
                if (w_idx_next == 2'd0) begin
                    r_snap_sec_tens <= sec_tens;
                    r_snap_min_ones <= min_ones;
                    r_snap_min_tens <= min_tens;
                end
                r_an  <= w_blank ? ANODE_OFF : ANODE_PAT[w_idx_next];
                r_seg <= w_blank ? SEG_BLANK : w_seg;
                r_dp  <= (w_idx_next != 2'd2);
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule : seg_display_scan
`default_nettype wire
